data_chk: RTL
=============

DATA_CHK -- requirements
Module: data_chk

Interface
REQ-001 Parameter DW, default 16, data width.
REQ-002 Parameter MAX_VAL, default 199, last value of the counting sequence 0..MAX_VAL.
REQ-003 Parameter LOCK_N, default 4, consecutive correct samples needed to declare lock.
REQ-004 Parameter LOSS_N, default 3, consecutive wrong samples needed to drop lock.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 data_en  input  1  sample qualifier; data_in is consumed only when high.
REQ-008 data_in  input  DW  received sample of the wrapping count stream.
REQ-009 locked  output  1  high while the checker is in LOCKED state.
REQ-010 err_pulse  output  1  one-cycle pulse per mismatched sample while LOCKED.
REQ-011 err_cnt  output  16  total mismatches while LOCKED, saturating at 16'hFFFF.
REQ-012 wrap_cnt  output  16  completed sequences while LOCKED, wraps modulo 2^16.
REQ-013 last_bad  output  DW  most recent mismatched data_in value.

Function
REQ-014 next(x) SHALL be 0 when x == MAX_VAL, else x+1, computed at DW bits.
REQ-015 The FSM SHALL have three states: HUNT, SYNC, LOCKED.
REQ-016 Cycles with data_en low SHALL not change state, counters, expected value or outputs, except that err_pulse returns to 0.
REQ-017 HUNT: a valid sample with data_in <= MAX_VAL SHALL load expected = next(data_in), match_cnt = 1, and go to SYNC; a valid sample > MAX_VAL SHALL be ignored.
REQ-018 SYNC: a valid sample equal to expected SHALL advance expected and increment match_cnt; when the increment reaches LOCK_N, the FSM SHALL go to LOCKED.
REQ-019 SYNC: a valid sample not equal to expected SHALL restart as in HUNT (reload from data_in if <= MAX_VAL, else return to HUNT); err_cnt SHALL not change.
REQ-020 LOCKED: expected SHALL advance by next() on every valid sample, match or not; the stream is not re-aligned while LOCKED.
REQ-021 LOCKED match: miss_cnt SHALL clear; if data_in == MAX_VAL, wrap_cnt SHALL increment.
REQ-022 LOCKED mismatch: err_pulse = 1 in the next cycle, err_cnt += 1 (saturating), last_bad = data_in, miss_cnt += 1.
REQ-023 When miss_cnt reaches LOSS_N, the FSM SHALL go to HUNT and locked SHALL fall in the same cycle that err_pulse is high.
REQ-024 All outputs SHALL be registered; latency from the deciding sample edge to the output change SHALL be one clock.
REQ-025 locked SHALL rise on the clock edge that captures the LOCK_N-th consecutive correct sample (counting the HUNT sample as 1).
REQ-026 err_cnt, wrap_cnt and last_bad SHALL persist across loss of lock; only rst clears them.
REQ-027 A data_en gap of any length SHALL not break a run of matches or misses.
REQ-028 Sample wrap (MAX_VAL followed by 0) SHALL count as a match; 0 following any value other than MAX_VAL SHALL be a mismatch.

Reset
REQ-029 On rst high, immediately and independently of clk: state = HUNT; locked = 0; err_pulse = 0; err_cnt = 0; wrap_cnt = 0; last_bad = 0; match_cnt = 0; miss_cnt = 0; expected = 0.
REQ-030 Reset asserted mid-stream SHALL discard lock; after release, lock SHALL be reacquired only after LOCK_N fresh correct samples.

Verification
REQ-031 Reset release, then continuous data_en=1 with data_in 0,1,2,... -> locked rises on the edge capturing 3; err_cnt = 0.
REQ-032 Locked stream runs 0..199 twice -> wrap_cnt = 2 after the second 199; no err_pulse.
REQ-033 Locked stream 10,11,55,13 -> single err_pulse after 55; err_cnt = 1; last_bad = 55; locked stays 1.
REQ-034 Locked stream followed by three consecutive wrong values -> err_cnt += 3; locked falls with the third pulse; FSM in HUNT.
REQ-035 Stream 5,6,data_en low for 10 cycles,7,8 -> locked after 8; data_in values during data_en low are ignored.
REQ-036 HUNT with data_in = 300 -> stays HUNT; rst pulse while locked with err_cnt = 5 -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/data_chk_if.sv
// Stream checker bus: the sample stream coming in and the lock/error status going out.
//   master : drives data_en/data_in, observes status (testbench or upstream source)
//   slave  : consumes data_en/data_in, drives status (data_chk)
//   data_en   - sample qualifier
//   data_in   - received sample of the wrapping count stream
//   locked    - checker is aligned to the stream
//   err_pulse - one-cycle flag per mismatched sample while locked
//   err_cnt   - saturating mismatch count while locked
//   wrap_cnt  - completed sequences while locked (modulo 2^16)
//   last_bad  - most recent mismatched sample
interface data_chk_if #(
    parameter int unsigned DW = 16
);
    logic          data_en;
    logic [DW-1:0] data_in;
    logic          locked;
    logic          err_pulse;
    logic [15:0]   err_cnt;
    logic [15:0]   wrap_cnt;
    logic [DW-1:0] last_bad;

    modport master (
        output data_en, data_in,
        input  locked, err_pulse, err_cnt, wrap_cnt, last_bad
    );

    modport slave (
        input  data_en, data_in,
        output locked, err_pulse, err_cnt, wrap_cnt, last_bad
    );
endinterface

// File: rtl/data_chk.sv
// Checker for a wrapping count stream 0..MAX_VAL.
// Hunts for a plausible sample, confirms LOCK_N consecutive correct samples,
// then tracks the stream free-running and counts mismatches and wraps.
// Lock is dropped after LOSS_N consecutive mismatches.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - data_chk_if slave port (sample stream in, status out)
module data_chk #(
    parameter int unsigned DW      = 16,
    parameter int unsigned MAX_VAL = 199,
    parameter int unsigned LOCK_N  = 4,
    parameter int unsigned LOSS_N  = 3
) (
    input  logic       clk,
    input  logic       rst,
    data_chk_if.slave  bus
);
    localparam int unsigned MW = $clog2(LOCK_N + 1);
    localparam int unsigned SW = $clog2(LOSS_N + 1);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_VAL);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] expected;
    logic [MW-1:0] match_cnt;
    logic [SW-1:0] miss_cnt;

    logic          locked_q;
    logic          err_pulse_q;
    logic [15:0]   err_cnt_q;
    logic [15:0]   wrap_cnt_q;
    logic [DW-1:0] last_bad_q;

    // Successor in the counting sequence
    function automatic logic [DW-1:0] nxt(input logic [DW-1:0] x);
        return (x == MAX_D) ? '0 : x + DW'(1);
    endfunction

    logic [DW-1:0] din;
    logic          din_in_range;
    logic          din_match;

    assign din          = bus.data_in;
    assign din_in_range = (din <= MAX_D);
    assign din_match    = (din == expected);

    // Checker FSM with registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            expected    <= '0;
            match_cnt   <= '0;
            miss_cnt    <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
            last_bad_q  <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.data_en) begin
                if (state == LOCKED) begin
                    // Free-running: never re-align while locked
                    expected <= nxt(expected);
                    if (din_match) begin
                        miss_cnt <= '0;
                        if (din == MAX_D) begin
                            wrap_cnt_q <= wrap_cnt_q + 16'd1;
                        end
                    end else begin
                        err_pulse_q <= 1'b1;
                        last_bad_q  <= din;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_q <= err_cnt_q + 16'd1;
                        end
                        if (miss_cnt + SW'(1) == SW'(LOSS_N)) begin
                            state     <= HUNT;
                            locked_q  <= 1'b0;
                            miss_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + SW'(1);
                        end
                    end
                end else if (state == SYNC && din_match) begin
                    expected  <= nxt(expected);
                    match_cnt <= match_cnt + MW'(1);
                    if (match_cnt + MW'(1) == MW'(LOCK_N)) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                        miss_cnt <= '0;
                    end
                end else if (din_in_range) begin
                    // HUNT, or SYNC mismatch: restart alignment from this sample
                    expected  <= nxt(din);
                    match_cnt <= MW'(1);
                    if (LOCK_N <= 1) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                        miss_cnt <= '0;
                    end else begin
                        state <= SYNC;
                    end
                end else begin
                    // Out-of-range sample cannot start a sequence
                    state     <= HUNT;
                    match_cnt <= '0;
                end
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.wrap_cnt  = wrap_cnt_q;
    assign bus.last_bad  = last_bad_q;
endmodule
